// File: rtl/ring_switch_pkg.sv
// rtl/ring_switch_pkg.sv - shared constants and helpers for the N-port ring switch
package ring_switch_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 32;

  // Widest port vector popcount can count; port masks are zero-extended to this.
  localparam int MAX_PORTS = 64;

  function automatic int unsigned ring_succ(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

  function automatic int unsigned ring_pred(input int unsigned idx, input int unsigned n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

  function automatic logic [31:0] popcount(input logic [MAX_PORTS-1:0] m);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      c = c + {31'd0, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sw_fifo.sv
// rtl/sw_fifo.sv - synchronous FIFO with occupancy count; pop-first when pushing and popping together
module sw_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored, so it never sees a same-cycle push.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ring_switch_n.sv
// rtl/ring_switch_n.sv - N-port multicast packet switch on a rotating slot ring
module ring_switch_n
  import ring_switch_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           ip_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]    ip_data,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] ip_dest,
  output logic [NUM_PORTS-1:0]           ip_suspend,
  output logic [NUM_PORTS-1:0]           op_valid,
  output logic [NUM_PORTS*DATA_W-1:0]    op_data,
  input  logic [NUM_PORTS-1:0]           op_suspend,
  output logic [CNT_W-1:0]               pkts_in,
  output logic [CNT_W-1:0]               pkts_out,
  output logic [CNT_W-1:0]               pkts_dropped
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = DATA_W + NUM_PORTS;

  typedef logic [NUM_PORTS-1:0] mask_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    mask_t             mask;
  } slot_t;

  slot_t             ring    [NUM_PORTS];
  slot_t             resid   [NUM_PORTS];
  slot_t             in_head [NUM_PORTS];
  logic [DATA_W-1:0] out_head[NUM_PORTS];
  // Occupancy of every FIFO: input FIFOs at [0, N), output FIFOs at [N, 2N).
  logic [CW-1:0]     fifo_cnt[2*NUM_PORTS];

  logic [NUM_PORTS-1:0] in_push, in_pop, in_full, in_empty, ip_rej;
  logic [NUM_PORTS-1:0] out_push, out_pop, out_full, out_empty;

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_port
    slot_t in_word;
    assign in_word = {ip_data[j*DATA_W +: DATA_W], ip_dest[j*NUM_PORTS +: NUM_PORTS]};

    sw_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(IW)) u_in_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_push[j]),
      .push_data (in_word),
      .pop       (in_pop[j]),
      .pop_data  (in_head[j]),
      .full      (in_full[j]),
      .empty     (in_empty[j]),
      .count     (fifo_cnt[j])
    );

    sw_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (out_push[j]),
      .push_data (ring[j].data),
      .pop       (out_pop[j]),
      .pop_data  (out_head[j]),
      .full      (out_full[j]),
      .empty     (out_empty[j]),
      .count     (fifo_cnt[NUM_PORTS + j])
    );

    // One entry of slack so a source reacting a cycle late still lands.
    assign ip_suspend[j] = (fifo_cnt[j] >= CW'(FIFO_DEPTH - 1));
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      in_push[j]  = ip_valid[j] && (ip_dest[j*NUM_PORTS +: NUM_PORTS] != '0) && !in_full[j];
      ip_rej[j]   = ip_valid[j] && !in_push[j];
      out_push[j] = ring[j].mask[j] && !out_full[j];
      resid[j]    = ring[j];
      if (out_push[j]) begin
        resid[j].mask[j] = 1'b0;
      end
      out_pop[j]  = !out_empty[j] && !op_suspend[j];
    end
    // Circulating traffic owns the slot; injection only fills a hole.
    for (int j = 0; j < NUM_PORTS; j++) begin
      in_pop[j] = (resid[ring_succ(j, NUM_PORTS)].mask == '0) && !in_empty[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        ring[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (resid[ring_succ(j, NUM_PORTS)].mask != '0) begin
          ring[j] <= resid[ring_succ(j, NUM_PORTS)];
        end else if (in_pop[j]) begin
          ring[j] <= in_head[j];
        end else begin
          ring[j] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid     <= '0;
      op_data      <= '0;
      pkts_in      <= '0;
      pkts_out     <= '0;
      pkts_dropped <= '0;
    end else begin
      op_valid <= out_pop;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (out_pop[j]) begin
          op_data[j*DATA_W +: DATA_W] <= out_head[j];
        end
      end
      pkts_in      <= pkts_in      + CNT_W'(popcount(MAX_PORTS'(in_push)));
      pkts_out     <= pkts_out     + CNT_W'(popcount(MAX_PORTS'(out_pop)));
      pkts_dropped <= pkts_dropped + CNT_W'(popcount(MAX_PORTS'(ip_rej)));
    end
  end

endmodule

// File: tb/tb_ring_switch_n.sv
// tb/tb_ring_switch_n.sv - directed and randomized bench for ring_switch_n
module tb_ring_switch_n;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    ip_valid, ip_suspend, op_valid, op_suspend;
  logic [N*DW-1:0] ip_data, op_data;
  logic [N*N-1:0]  ip_dest;
  logic [CW-1:0]   pkts_in, pkts_out, pkts_dropped;

  int n_asserts = 0;
  int n_fail    = 0;

  ring_switch_n #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ip_valid     (ip_valid),
    .ip_data      (ip_data),
    .ip_dest      (ip_dest),
    .ip_suspend   (ip_suspend),
    .op_valid     (op_valid),
    .op_data      (op_data),
    .op_suspend   (op_suspend),
    .pkts_in      (pkts_in),
    .pkts_out     (pkts_out),
    .pkts_dropped (pkts_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ip_valid = '0;
    ip_data  = '0;
    ip_dest  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    op_suspend = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_counters(input string tag, input int ein, input int eout, input int edrop);
    check({tag, " pkts_in"}, pkts_in, ein);
    check({tag, " pkts_out"}, pkts_out, eout);
    check({tag, " pkts_dropped"}, pkts_dropped, edrop);
  endtask

  // Unloaded-ring latency model: copy s->d appears T+3+((s-d) mod N) edges after acceptance.
  int             lat_src [$];
  logic [N-1:0]   lat_mask[$];
  logic [DW-1:0]  lat_data[$];

  task automatic drive(input int s, input logic [DW-1:0] d, input logic [N-1:0] m);
    ip_valid[s]        = 1'b1;
    ip_data[s*DW +: DW] = d;
    ip_dest[s*N +: N]   = m;
  endtask

  task automatic send(input int s, input logic [DW-1:0] d, input logic [N-1:0] m);
    drive(s, d, m);
    lat_src.push_back(s);
    lat_mask.push_back(m);
    lat_data.push_back(d);
  endtask

  task automatic check_window(input string tag, input int ncyc);
    logic [N-1:0]  ev;
    logic [DW-1:0] ed [N];
    for (int k = 1; k <= ncyc; k++) begin
      step();
      ev = '0;
      for (int dd = 0; dd < N; dd++) ed[dd] = '0;
      for (int e = 0; e < lat_src.size(); e++) begin
        for (int dd = 0; dd < N; dd++) begin
          if (lat_mask[e][dd] && (3 + ((lat_src[e] - dd + N) % N)) == k) begin
            ev[dd] = 1'b1;
            ed[dd] = lat_data[e];
          end
        end
      end
      check($sformatf("%s op_valid edge+%0d", tag, k), op_valid, ev);
      for (int dd = 0; dd < N; dd++) begin
        if (ev[dd]) check($sformatf("%s op_data[%0d] edge+%0d", tag, dd, k), op_data[dd*DW +: DW], ed[dd]);
      end
    end
    lat_src.delete();
    lat_mask.delete();
    lat_data.delete();
  endtask

  logic [DW-1:0] expq [N][$];

  task automatic scoreboard();
    int found;
    for (int dd = 0; dd < N; dd++) begin
      if (op_valid[dd]) begin
        found = -1;
        for (int i = 0; i < expq[dd].size(); i++) begin
          if (found < 0 && expq[dd][i] == op_data[dd*DW +: DW]) found = i;
        end
        check($sformatf("rand beat port %0d data %0h expected", dd, op_data[dd*DW +: DW]), found >= 0, 1);
        if (found >= 0) expq[dd].delete(found);
      end
    end
  endtask

  initial begin
    int sent, guard, cnt, seen;
    logic [6:0] got;
    logic [DW-1:0] v;
    logic [N-1:0] m;
    int exp_in, exp_out, exp_drop, seq, left;

    idle_inputs();
    op_suspend = '0;
    #1 reset = 1'b1;
    #2;
    check("reset op_valid", op_valid, 0);
    check("reset op_data", op_data, 0);
    check("reset ip_suspend", ip_suspend, 0);
    check_counters("reset", 0, 0, 0);
    step();
    reset = 1'b0;

    // Unicast one hop downstream.
    send(1, 16'hA5A5, 4'b0001);
    step();
    idle_inputs();
    check_window("t1", 8);
    check_counters("t1", 1, 1, 0);

    // Multicast to three ports.
    do_reset();
    send(0, 16'h1234, 4'b1110);
    step();
    idle_inputs();
    check_window("t2", 10);
    check_counters("t2", 1, 3, 0);

    // Zero mask is dropped.
    do_reset();
    send(2, 16'hDEAD, 4'b0000);
    step();
    idle_inputs();
    check_window("t3", 20);
    check_counters("t3", 0, 0, 1);

    // Sink backpressure: out-FIFO fills, remainder circulates.
    do_reset();
    op_suspend = 4'b0100;
    sent = 0;
    guard = 0;
    while (sent < 6 && guard < 200) begin
      idle_inputs();
      if (!ip_suspend[3]) begin
        drive(3, DW'(sent + 1), 4'b0100);
        sent++;
      end
      step();
      guard++;
    end
    idle_inputs();
    check("t4 beats injected", sent, 6);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (op_valid != '0) seen++;
    end
    check("t4 held op_valid beats", seen, 0);
    check_counters("t4 held", 6, 0, 0);
    op_suspend = '0;
    cnt = 0;
    seen = 0;
    got = '0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (op_valid[2]) begin
        cnt++;
        v = op_data[2*DW +: DW];
        if (v >= 1 && v <= 6) got[v[2:0]] = 1'b1;
      end
      if ((op_valid & 4'b1011) != '0) seen++;
    end
    check("t4 port2 beats", cnt, 6);
    check("t4 port2 values", got, 7'b1111110);
    check("t4 other ports", seen, 0);
    check_counters("t4 released", 6, 6, 0);

    // All ports at once, one hop upstream destination each.
    do_reset();
    for (int j = 0; j < N; j++) send(j, DW'(16'hB000 + j), N'(1 << ((j + 1) % N)));
    step();
    idle_inputs();
    check_window("t5", 10);
    check_counters("t5", 4, 4, 0);

    // Asynchronous reset in the middle of traffic.
    do_reset();
    op_suspend = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      if (!ip_suspend[3]) drive(3, DW'(k + 1), 4'b0100);
      if (!ip_suspend[0]) drive(0, DW'(k + 16'h100), 4'b0010);
      step();
    end
    check("t6 traffic before reset", pkts_in != 0, 1);
    #2 reset = 1'b1;
    #1;
    check("t6 async op_valid", op_valid, 0);
    check("t6 async ip_suspend", ip_suspend, 0);
    check_counters("t6 async", 0, 0, 0);
    idle_inputs();
    op_suspend = '0;
    step();
    step();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (op_valid != '0) seen++;
    end
    check("t6 quiet after reset", seen, 0);

    // Randomized traffic against an unordered per-destination scoreboard.
    do_reset();
    exp_in = 0;
    exp_out = 0;
    exp_drop = 0;
    seq = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      scoreboard();
      idle_inputs();
      op_suspend = '0;
      if (cyc < 300) begin
        for (int j = 0; j < N; j++) begin
          if (!ip_suspend[j] && $urandom_range(0, 1) == 1) begin
            m = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 15));
            v = {2'(j), 14'(seq)};
            seq++;
            drive(j, v, m);
            if (m == '0) begin
              exp_drop++;
            end else begin
              exp_in++;
              for (int dd = 0; dd < N; dd++) begin
                if (m[dd]) begin
                  expq[dd].push_back(v);
                  exp_out++;
                end
              end
            end
          end
          op_suspend[j] = ($urandom_range(0, 3) == 0);
        end
      end
      step();
    end
    scoreboard();
    left = 0;
    for (int dd = 0; dd < N; dd++) left += expq[dd].size();
    check("rand undelivered copies", left, 0);
    check_counters("rand", exp_in, exp_out, exp_drop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_switch_n.md
Name: ring_switch_n

Overview:
N-port packet switch built on a rotating slot ring. It generalises the fixed 4-port ring switch to a configurable port count, data width and FIFO depth, and adds multicast destination masks, single-phase operation (deliver and shift in the same cycle) and drop accounting. It sits between N port agents/drivers and N sinks in the switch testbench environment and is the DUT for the next verification component.

Parameters:
NUM_PORTS, 4, number of ports and ring slots (>=2)
DATA_W, 16, payload width per packet
FIFO_DEPTH, 4, entries per input FIFO and per output FIFO (>=2)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-high
ip_valid  input  NUM_PORTS  per-port input beat valid
ip_data  input  NUM_PORTS*DATA_W  per-port payload; port j at [j*DATA_W +: DATA_W]
ip_dest  input  NUM_PORTS*NUM_PORTS  per-port one-hot-or-multi destination mask; port j at [j*NUM_PORTS +: NUM_PORTS]
ip_suspend  output  NUM_PORTS  per-port input backpressure
op_valid  output  NUM_PORTS  per-port output beat valid, registered
op_data  output  NUM_PORTS*DATA_W  per-port output payload, registered
op_suspend  input  NUM_PORTS  per-port sink backpressure
pkts_in  output  CNT_W  accepted input beats
pkts_out  output  CNT_W  delivered output beats (each multicast copy counts)
pkts_dropped  output  CNT_W  rejected input beats

Behaviour:
- Reset: async assert clears all input/output FIFOs and all ring slots to empty. op_valid=0, op_data=0, counters=0. ip_suspend=0 follows from the empty FIFOs. In-flight packets are lost and not counted as dropped. Leaving reset is synchronous to clk.
- Ring slot contents: {data, residual mask}. A slot is empty iff its mask==0.
- Input accept, per port j, at posedge with ip_valid[j]=1:
  - mask==0: drop, pkts_dropped+1.
  - else if in-FIFO j is full: drop, pkts_dropped+1.
  - else push, pkts_in+1.
- Counter increments are summed across ports in a single cycle. Counters wrap modulo 2^CNT_W.
- ip_suspend[j] is combinational and asserted when in-FIFO j occupancy >= FIFO_DEPTH-1. This leaves one beat of slack for a source that stops on the following cycle.
- Delivery, each cycle, per slot i: if mask bit i is set and out-FIFO i is not full, push data to out-FIFO i and clear bit i to form the residual mask m'_i. If out-FIFO i is full, the bit stays set and the packet keeps circulating.
- Shift, same edge: next slot[j] is chosen in priority order:
  - upstream slot[(j+1) mod N] if its m' != 0 (ring traffic has priority, so there is no in-ring loss);
  - else the head popped from in-FIFO j, if non-empty;
  - else empty.
- Ring direction is slot j+1 -> slot j, wrapping 0 -> N-1.
- Loopback (own bit set in mask) is legal and is delivered at slot j.
- Output, per port j, at posedge: if out-FIFO j is non-empty and op_suspend[j]=0, pop it, drive op_data, set op_valid=1 and add 1 to pkts_out. Otherwise op_valid=0 and op_data holds its last value. There is no same-cycle bypass from push to pop.
- Latency: for a beat accepted at edge T from source s to destination d, with the ring unloaded, op_valid rises at edge T+3+h, where h=(s-d) mod N.
- Ordering:
  - Same source to same destination is preserved while no backpressure acts.
  - Under out-FIFO full, reordering is permitted.
  - Each copy is delivered exactly once.
- Simultaneous push and pop on any FIFO in the same cycle is legal, including when full (pop first, so the push succeeds) and when empty (the pop does not see the pushed entry).
- Starvation of injection under sustained ring load is permitted. It is bounded only by sink drain.

Decomposition:
- Package ring_switch_pkg holds:
  - a function for ring predecessor/successor index;
  - a function for popcount of a mask;
  - constants for the default parameters.
- Parametrised structs stay local to the module because they depend on the parameters.
- One sub-module: sw_fifo (sync FIFO with DEPTH and WIDTH parameters; push, pop, full, empty, count; async reset). It is instantiated 2*NUM_PORTS times.

Test Plan:
1. Reset, then port 1 sends data 16'hA5A5 with mask 4'b0001 -> op_valid[0]=1 with op_data[0]=16'hA5A5 at edge T+4, one cycle wide; pkts_in=1, pkts_out=1, pkts_dropped=0.
2. Port 0 sends 16'h1234 with mask 4'b1110 -> copies appear on port 3 at T+4, port 2 at T+5 and port 1 at T+6; pkts_out=3.
3. Port 2 sends a beat with mask 4'b0000 -> no op_valid anywhere for 20 cycles; pkts_dropped=1, pkts_in=0.
4. op_suspend[2]=1 while port 3 sends 6 beats (16'h0001..16'h0006) to mask 4'b0100, obeying ip_suspend:
   - out-FIFO 2 fills to 4 and the remaining packets circulate;
   - release op_suspend -> exactly 6 op_valid beats on port 2 carrying the values 1..6 in any order; pkts_out=6, pkts_dropped=0.
5. All 4 ports send in the same cycle to mask 1<<((j+1) mod 4) -> each port receives exactly one beat; pkts_in=4, pkts_out=4, with no loss under ring contention.
6. Assert reset asynchronously mid-burst (between clock edges) during test 4 -> op_valid=0, counters=0 and ip_suspend=0 immediately; no op_valid for 20 cycles after release.
